// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StExecI   = 4'd7,
    StAluWb   = 4'd8,
    StBranch  = 4'd9,
    StUnknown = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Unsupported commands fall back to ADD.
  function automatic logic [1:0] alu_decode(input logic alu_op, input logic [3:0] cmd);
    logic [1:0] ctl;
    ctl = ALU_ADD;
    if (alu_op) begin
      case (cmd)
        CMD_SUB: ctl = ALU_SUB;
        CMD_AND: ctl = ALU_AND;
        CMD_ORR: ctl = ALU_ORR;
        default: ctl = ALU_ADD;
      endcase
    end
    return ctl;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flags register and condition evaluation; cond_ex always reflects the stored flags.
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flag_write_nz,
  input  logic       flag_write_cv,
  output logic       cond_ex
);

  logic [3:0] flags_q;
  logic       n, z, v;
  logic       unused_carry;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      if (flag_write_nz) flags_q[3:2] <= alu_flags[3:2];
      if (flag_write_cv) flags_q[1:0] <= alu_flags[1:0];
    end
  end

  assign n            = flags_q[3];
  assign z            = flags_q[2];
  assign v            = flags_q[0];
  // Carry is kept for completeness but no supported condition reads it.
  assign unused_carry = flags_q[1];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: Moore main FSM, ALU decoder and gated write strobes.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter bit UNKNOWN_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] alu_flags,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [3:0] state_dbg
);

  state_t state_q, state_d;
  logic   next_pc, branch, reg_w, mem_w, ir_w, alu_op;
  logic   cond_ex, in_exec, flag_write_nz, flag_write_cv;
  logic [3:0] cmd;

  assign cmd = funct[4:1];

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          OP_MEM:  state_d = StMemAdr;
          OP_DP:   state_d = funct[5] ? StExecI : StExecR;
          OP_BR:   state_d = StBranch;
          default: state_d = StUnknown;
        endcase
      end
      StMemAdr:  state_d = funct[0] ? StMemRd : StMemWr;
      StMemRd:   state_d = StMemWb;
      StExecR:   state_d = StAluWb;
      StExecI:   state_d = StAluWb;
      StUnknown: state_d = UNKNOWN_TRAP ? StUnknown : StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    alu_op     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    unique case (state_q)
      StFetch: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_w       = 1'b1;
        next_pc    = 1'b1;
      end
      StDecode: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      StMemAdr: alu_src_b = 2'b01;
      StMemRd:  adr_src = 1'b1;
      StMemWb: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      StMemWr: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      StExecR: alu_op = 1'b1;
      StExecI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      StAluWb: reg_w = 1'b1;
      StBranch: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      StUnknown: ;
      default: ;
    endcase
  end

  assign in_exec       = (state_q == StExecR) || (state_q == StExecI);
  assign flag_write_nz = in_exec & funct[0] & cond_ex;
  assign flag_write_cv = flag_write_nz & ((cmd == CMD_ADD) || (cmd == CMD_SUB));

  cond_unit u_cond_unit (
    .clk           (clk),
    .reset         (reset),
    .cond          (cond),
    .alu_flags     (alu_flags),
    .flag_write_nz (flag_write_nz),
    .flag_write_cv (flag_write_cv),
    .cond_ex       (cond_ex)
  );

  // Architectural strobes are suppressed for the whole reset cycle.
  assign pc_write  = ~reset & (next_pc | (branch & cond_ex));
  assign ir_write  = ~reset & ir_w;
  assign reg_write = ~reset & reg_w & cond_ex;
  assign mem_write = ~reset & mem_w & cond_ex;

  assign alu_control = alu_decode(alu_op, cmd);
  assign imm_src     = op;
  assign reg_src     = {op == OP_MEM, op == OP_BR};
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: driver queues per-cycle expectations, monitor checks.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] alu_flags;

  logic       pc_write, ir_write, adr_src, mem_write, reg_write, alu_src_a;
  logic [1:0] alu_src_b, result_src, alu_control, imm_src, reg_src;
  logic [3:0] state_dbg;

  logic       t_pc_write, t_ir_write, t_adr_src, t_mem_write, t_reg_write, t_alu_src_a;
  logic [1:0] t_alu_src_b, t_result_src, t_alu_control, t_imm_src, t_reg_src;
  logic [3:0] t_state_dbg;

  always #5 clk = ~clk;

  mc_controller #(.UNKNOWN_TRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .alu_flags(alu_flags),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_control(alu_control), .imm_src(imm_src),
    .reg_src(reg_src), .state_dbg(state_dbg)
  );

  mc_controller #(.UNKNOWN_TRAP(1'b1)) dut_trap (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .alu_flags(alu_flags),
    .pc_write(t_pc_write), .ir_write(t_ir_write), .adr_src(t_adr_src),
    .mem_write(t_mem_write), .reg_write(t_reg_write), .alu_src_a(t_alu_src_a),
    .alu_src_b(t_alu_src_b), .result_src(t_result_src), .alu_control(t_alu_control),
    .imm_src(t_imm_src), .reg_src(t_reg_src), .state_dbg(t_state_dbg)
  );

  typedef struct {
    int         id;
    logic [3:0] st;
    logic [3:0] strb;   // {pc_write, ir_write, mem_write, reg_write}
    logic       x_chk;
    logic [1:0] rsrc;
    logic [1:0] aluc;
    logic       t_chk;
    logic [3:0] t_st;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_id   = 0;

  task automatic check(input string nm, input int id, input logic [3:0] act,
                       input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc%0d: got %0h want %0h", nm, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("state", e.id, state_dbg, e.st);
      check("strobes", e.id, {pc_write, ir_write, mem_write, reg_write}, e.strb);
      if (e.x_chk) begin
        check("result_src", e.id, {2'b00, result_src}, {2'b00, e.rsrc});
        check("alu_control", e.id, {2'b00, alu_control}, {2'b00, e.aluc});
      end
      if (e.t_chk) check("trap_state", e.id, t_state_dbg, e.t_st);
    end
  end

  task automatic push(input logic [3:0] st, input logic [3:0] strb, input logic xc,
                      input logic [1:0] rsrc, input logic [1:0] aluc, input logic tc,
                      input logic [3:0] tst);
    exp_t e;
    e.id = cyc_id; e.st = st; e.strb = strb; e.x_chk = xc; e.rsrc = rsrc; e.aluc = aluc;
    e.t_chk = tc; e.t_st = tst;
    q.push_back(e);
    cyc_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic c(input logic [3:0] st, input logic [3:0] strb);
    push(st, strb, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0);
  endtask

  task automatic cx(input logic [3:0] st, input logic [3:0] strb, input logic [1:0] rsrc,
                    input logic [1:0] aluc);
    push(st, strb, 1'b1, rsrc, aluc, 1'b0, 4'd0);
  endtask

  task automatic ct(input logic [3:0] st, input logic [3:0] strb, input logic [3:0] tst);
    push(st, strb, 1'b0, 2'b00, 2'b00, 1'b1, tst);
  endtask

  task automatic instr(input logic [3:0] cd, input logic [1:0] o, input logic [5:0] f);
    cond = cd; op = o; funct = f;
  endtask

  initial begin
    reset = 1'b1; cond = 4'h0; op = 2'b00; funct = 6'h00; alu_flags = 4'h0;
    @(posedge clk);
    #1;
    // Two reset cycles: FETCH with every strobe held low.
    c(4'd0, 4'b0000);
    c(4'd0, 4'b0000);
    reset = 1'b0;

    // LDR AL
    instr(4'b1110, 2'b01, 6'b011001);
    c(4'd0, 4'b1100); c(4'd1, 4'b0000); c(4'd2, 4'b0000); c(4'd3, 4'b0000);
    cx(4'd4, 4'b0001, 2'b01, 2'b00);

    // STR EQ with Z=0: full walk, no memory write
    instr(4'b0000, 2'b01, 6'b011000);
    c(4'd0, 4'b1100); c(4'd1, 4'b0000); c(4'd2, 4'b0000); c(4'd5, 4'b0000);

    // SUBS register form, ALU reports Z
    instr(4'b1110, 2'b00, 6'b000101);
    alu_flags = 4'b0100;
    c(4'd0, 4'b1100); c(4'd1, 4'b0000);
    cx(4'd6, 4'b0000, 2'b00, 2'b01);
    cx(4'd8, 4'b0001, 2'b00, 2'b00);
    alu_flags = 4'b0000;

    // B EQ taken, B NE not taken
    instr(4'b0000, 2'b10, 6'b000000);
    c(4'd0, 4'b1100); c(4'd1, 4'b0000); c(4'd9, 4'b1000);
    instr(4'b0001, 2'b10, 6'b000000);
    c(4'd0, 4'b1100); c(4'd1, 4'b0000); c(4'd9, 4'b0000);

    // AND NE fails: no register write
    instr(4'b0001, 2'b00, 6'b000000);
    c(4'd0, 4'b1100); c(4'd1, 4'b0000);
    cx(4'd6, 4'b0000, 2'b00, 2'b10);
    c(4'd8, 4'b0000);

    // ORR immediate AL
    instr(4'b1110, 2'b00, 6'b111000);
    c(4'd0, 4'b1100); c(4'd1, 4'b0000);
    cx(4'd7, 4'b0000, 2'b00, 2'b11);
    cx(4'd8, 4'b0001, 2'b00, 2'b00);

    // B GT false (Z=1), B LE true
    instr(4'b1100, 2'b10, 6'b000000);
    c(4'd0, 4'b1100); c(4'd1, 4'b0000); c(4'd9, 4'b0000);
    instr(4'b1101, 2'b10, 6'b000000);
    c(4'd0, 4'b1100); c(4'd1, 4'b0000); c(4'd9, 4'b1000);

    // op=11: main DUT returns to FETCH, trapping DUT sticks in UNKNOWN
    instr(4'b1110, 2'b11, 6'b000000);
    ct(4'd0, 4'b1100, 4'd0); ct(4'd1, 4'b0000, 4'd1); ct(4'd10, 4'b0000, 4'd10);
    ct(4'd0, 4'b1100, 4'd10); ct(4'd1, 4'b0000, 4'd10); ct(4'd10, 4'b0000, 4'd10);

    // LDR interrupted by reset during MEMRD
    instr(4'b1110, 2'b01, 6'b011001);
    ct(4'd0, 4'b1100, 4'd10); c(4'd1, 4'b0000); c(4'd2, 4'b0000);
    reset = 1'b1;
    c(4'd3, 4'b0000);
    reset = 1'b0;

    // Flags cleared: B EQ not taken, B GE taken
    instr(4'b0000, 2'b10, 6'b000000);
    ct(4'd0, 4'b1100, 4'd0); c(4'd1, 4'b0000); c(4'd9, 4'b0000);
    instr(4'b1010, 2'b10, 6'b000000);
    c(4'd0, 4'b1100); c(4'd1, 4'b0000); c(4'd9, 4'b1000);

    repeat (3) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
